// File: rtl/axis_tg.sv
// AXI-Stream traffic generator: LFSR-throttled injection of single-beat packets to
// pseudo-random destinations, with per-destination sequence numbers and completion flag.
module axis_tg #(
  parameter logic [63:0] DEST_SEED   = 64'h1,
  parameter logic [15:0] LOAD_SEED   = 16'h1,
  parameter int          COUNT_WIDTH = 16,
  parameter int          TDATA_WIDTH = 32,
  parameter int          TDEST_WIDTH = 2,
  parameter int          TID_WIDTH   = 2,
  parameter int          TID         = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [15:0]              load,
  input  logic [COUNT_WIDTH-1:0]   num_packets,
  input  logic                     start,
  input  logic [TDATA_WIDTH/2-1:0] ticks,
  output logic                     done,
  output logic [COUNT_WIDTH-1:0]   sent_packets [2**TDEST_WIDTH],
  output logic                     axis_out_tvalid,
  input  logic                     axis_out_tready,
  output logic [TDATA_WIDTH-1:0]   axis_out_tdata,
  output logic                     axis_out_tlast,
  output logic [TID_WIDTH-1:0]     axis_out_tid,
  output logic [TDEST_WIDTH-1:0]   axis_out_tdest
);

  localparam int          HALF    = TDATA_WIDTH / 2;
  localparam int          NDEST   = 2**TDEST_WIDTH;
  localparam logic [15:0] L_SEED  = (LOAD_SEED == 16'h0) ? 16'h1 : LOAD_SEED;
  localparam logic [63:0] D_SEED  = (DEST_SEED == 64'h0) ? 64'h1 : DEST_SEED;
  localparam logic [15:0] L_MASK  = 16'hB400;
  localparam logic [63:0] D_MASK  = 64'hD800_0000_0000_0000;

  logic [15:0]            r_load_lfsr;
  logic [63:0]            r_dest_lfsr;
  logic [COUNT_WIDTH-1:0] r_issued;
  logic [COUNT_WIDTH-1:0] r_total;
  logic                   r_done;
  logic                   r_tvalid;
  logic [TDATA_WIDTH-1:0] r_tdata;
  logic [TDEST_WIDTH-1:0] r_tdest;
  logic                   r_tlast;
  logic [COUNT_WIDTH-1:0] r_sent [NDEST];

  logic                   w_active;
  logic                   w_hs;
  logic                   w_free;
  logic                   w_gen;
  logic [TDEST_WIDTH-1:0] w_dest;
  logic [COUNT_WIDTH-1:0] w_seq;
  logic [HALF-1:0]        w_seq_fit;
  logic [15:0]            w_load_next;
  logic [63:0]            w_dest_next;

  assign w_active    = start & ~r_done;
  assign w_hs        = r_tvalid & axis_out_tready;
  assign w_free      = ~r_tvalid | axis_out_tready;
  assign w_gen       = w_active && (r_issued < num_packets) && (r_load_lfsr <= load) && w_free;
  assign w_dest      = r_dest_lfsr[TDEST_WIDTH-1:0];
  assign w_load_next = {1'b0, r_load_lfsr[15:1]} ^ (r_load_lfsr[0] ? L_MASK : 16'h0);
  assign w_dest_next = {1'b0, r_dest_lfsr[63:1]} ^ (r_dest_lfsr[0] ? D_MASK : 64'h0);

  // A beat to the same destination retiring this cycle has already claimed the current count.
  always_comb begin
    w_seq = r_sent[w_dest];
    if (w_hs && (r_tdest == w_dest)) begin
      w_seq = r_sent[w_dest] + COUNT_WIDTH'(1);
    end
  end

  generate
    if (COUNT_WIDTH >= HALF) begin : g_trunc
      assign w_seq_fit = w_seq[HALF-1:0];
    end else begin : g_zext
      assign w_seq_fit = {{(HALF-COUNT_WIDTH){1'b0}}, w_seq};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_lfsr <= L_SEED;
      r_dest_lfsr <= D_SEED;
      r_issued    <= '0;
      r_total     <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_active) r_load_lfsr <= w_load_next;
      if (w_gen) begin
        r_dest_lfsr <= w_dest_next;
        r_issued    <= r_issued + COUNT_WIDTH'(1);
      end
      if (w_hs) r_total <= r_total + COUNT_WIDTH'(1);
      r_done <= r_done | (r_total == num_packets);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tdest  <= '0;
      r_tlast  <= 1'b0;
    end else if (w_gen) begin
      r_tvalid <= 1'b1;
      r_tdata  <= {ticks, w_seq_fit};
      r_tdest  <= w_dest;
      r_tlast  <= 1'b1;
    end else if (w_hs) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NDEST; i++) r_sent[i] <= '0;
    end else begin
      for (int i = 0; i < NDEST; i++) begin
        if (w_hs && (r_tdest == TDEST_WIDTH'(i))) r_sent[i] <= r_sent[i] + COUNT_WIDTH'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDEST; gi++) begin : g_sent_out
      assign sent_packets[gi] = r_sent[gi];
    end
  endgenerate

  assign done            = r_done;
  assign axis_out_tvalid = r_tvalid;
  assign axis_out_tdata  = r_tdata;
  assign axis_out_tdest  = r_tdest;
  assign axis_out_tlast  = r_tlast;
  assign axis_out_tid    = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_tg.sv
// Directed bench for axis_tg: reset, burst, stall, zero load, start gating and 25% load runs,
// checked against a bench-side destination LFSR model and per-destination sequence counters.
module tb_axis_tg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] load = '0;
  logic [15:0] num_packets = '0;
  logic        start = 1'b0;
  logic [15:0] ticks = '0;
  logic        done;
  logic [15:0] sent_packets [4];
  logic        tvalid;
  logic        tready = 1'b0;
  logic [31:0] tdata;
  logic        tlast;
  logic [1:0]  tid;
  logic [1:0]  tdest;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] m_dest;
  int          exp_seq [4];
  int          beats;

  axis_tg #(.TID(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .load            (load),
    .num_packets     (num_packets),
    .start           (start),
    .ticks           (ticks),
    .done            (done),
    .sent_packets    (sent_packets),
    .axis_out_tvalid (tvalid),
    .axis_out_tready (tready),
    .axis_out_tdata  (tdata),
    .axis_out_tlast  (tlast),
    .axis_out_tid    (tid),
    .axis_out_tdest  (tdest)
  );

  always #5 clk = ~clk;
  always @(negedge clk) ticks = ticks + 16'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] next64(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
  endfunction

  function automatic int sum_sent();
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(sent_packets[i]);
    return s;
  endfunction

  // Called once per freshly loaded beat, sampled just after the loading edge.
  task automatic check_beat();
    logic [1:0] ed;
    ed = m_dest[1:0];
    chk("tdest", 64'(tdest), 64'(ed));
    chk("tlast", 64'(tlast), 64'd1);
    chk("tid", 64'(tid), 64'd2);
    chk("tdata_ticks", 64'(tdata[31:16]), 64'(ticks));
    chk("tdata_seq", 64'(tdata[15:0]), 64'(exp_seq[ed]));
    exp_seq[ed]++;
    m_dest = next64(m_dest);
    beats++;
  endtask

  task automatic do_reset(input logic [15:0] ld, input logic [15:0] np, input logic st, input logic rdy);
    rst_n = 1'b0;
    load = ld;
    num_packets = np;
    start = st;
    tready = rdy;
    m_dest = 64'h1;
    for (int i = 0; i < 4; i++) exp_seq[i] = 0;
    beats = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first, last, cnt, cycles, held_ts;

    // Reset values while held in reset
    load = 16'hFFFF; num_packets = 16'd4; start = 1'b1; tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tdest", 64'(tdest), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sent", 64'(sum_sent()), 64'd0);
    $display("step: reset values");

    // num_packets = 0 finishes immediately
    do_reset(16'hFFFF, 16'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    chk("np0_done", 64'(done), 64'd1);
    chk("np0_tvalid", 64'(tvalid), 64'd0);
    $display("step: num_packets=0");

    // Full load, four back-to-back beats
    do_reset(16'hFFFF, 16'd4, 1'b1, 1'b1);
    first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (tvalid) begin
        check_beat();
        if (first < 0) first = c;
        last = c;
      end
      if (beats == 4 && c == last + 2) chk("burst_done_timing", 64'(done), 64'd1);
    end
    chk("burst_beats", 64'(beats), 64'd4);
    chk("burst_consecutive", 64'(last - first), 64'd3);
    chk("burst_sum", 64'(sum_sent()), 64'd4);
    chk("burst_done", 64'(done), 64'd1);
    rst_n = 1'b0; #1;
    chk("burst_rst_done", 64'(done), 64'd0);
    chk("burst_rst_sum", 64'(sum_sent()), 64'd0);
    $display("step: burst of 4");

    // Stall for 10 cycles, then release; then reset with a beat pending
    do_reset(16'hFFFF, 16'd4, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("stall_tvalid0", 64'(tvalid), 64'd1);
    held_ts = int'(ticks);
    check_beat();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("stall_tvalid", 64'(tvalid), 64'd1);
      chk("stall_tdata", 64'(tdata), 64'({held_ts[15:0], 16'h0}));
      chk("stall_tdest", 64'(tdest), 64'd1);
      chk("stall_sum", 64'(sum_sent()), 64'd0);
    end
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    chk("stall_sent1", 64'(sent_packets[1]), 64'd1);
    chk("stall_sum1", 64'(sum_sent()), 64'd1);
    chk("stall_next_valid", 64'(tvalid), 64'd1);
    check_beat();
    rst_n = 1'b0; #1;
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum", 64'(sum_sent()), 64'd0);
    chk("midrst_tdata", 64'(tdata), 64'd0);
    $display("step: stall and mid-run reset");

    // load = 0 never injects
    do_reset(16'h0000, 16'd4, 1'b1, 1'b1);
    cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (tvalid) cnt++;
    end
    chk("load0_valids", 64'(cnt), 64'd0);
    chk("load0_done", 64'(done), 64'd0);
    $display("step: load=0");

    // Drop start with a beat pending, then resume
    do_reset(16'hFFFF, 16'd6, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("sd_tvalid0", 64'(tvalid), 64'd1);
    check_beat();
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("sd_pending", 64'(tvalid), 64'd1);
    end
    tready = 1'b1;
    @(posedge clk); #1;
    chk("sd_drained", 64'(tvalid), 64'd0);
    chk("sd_sum1", 64'(sum_sent()), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("sd_idle", 64'(tvalid), 64'd0);
    end
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (tvalid) check_beat();
    end
    chk("sd_beats", 64'(beats), 64'd6);
    chk("sd_sum", 64'(sum_sent()), 64'd6);
    chk("sd_done", 64'(done), 64'd1);
    $display("step: start gating");

    // 25% offered load, 1024 packets
    do_reset(16'h4000, 16'd1024, 1'b1, 1'b1);
    cycles = 8000;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #1;
      if (tvalid) check_beat();
      if (done) begin
        cycles = c;
        break;
      end
    end
    chk("q_done", 64'(done), 64'd1);
    chk("q_beats", 64'(beats), 64'd1024);
    chk("q_sum", 64'(sum_sent()), 64'd1024);
    chk("q_rate", 64'(cycles >= 2600 && cycles <= 6000), 64'd1);
    $display("step: 25%% load, %0d cycles", cycles);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
